// File: rtl/mux3_rr_arbiter_if.sv
// Handshake bundle between three requesters sharing mux33 and the arbiter
// that sequences them onto a single valid/ready beat stream.
interface mux3_rr_arbiter_if;
   logic [2:0] req;
   logic [2:0] last;
   logic [2:0] gnt;
   logic [1:0] s;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   // Arbiter side: consumes requests and downstream ready, drives grant/select.
   modport slave (
      input  req,
      input  last,
      input  out_ready,
      output gnt,
      output s,
      output out_valid,
      output busy
   );

   // Requester/consumer side.
   modport master (
      output req,
      output last,
      output out_ready,
      input  gnt,
      input  s,
      input  out_valid,
      input  busy
   );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for the three-input mux33 datapath: grants one owner at a
// time, holds the mux select stable, and rotates after last beat, withdrawal or MAX_HOLD beats.
module mux3_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   mux3_rr_arbiter_if.slave    bus
);

   localparam int unsigned       CNT_W    = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(MAX_HOLD);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        ptr_q,   ptr_d;
   logic [1:0]        s_q,     s_d;
   logic [2:0]        gnt_q,   gnt_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [CNT_W-1:0]  cnt_inc;

   logic [1:0]        cand0, cand1, cand2;
   logic [1:0]        pick;
   logic              any_req;
   logic              owner_req;
   logic              owner_last;
   logic              valid;
   logic              xfer;
   logic              grant_end;

   function automatic logic [1:0] next_mod3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // Search order starts at the priority pointer and wraps modulo 3.
   assign cand0   = ptr_q;
   assign cand1   = next_mod3(cand0);
   assign cand2   = next_mod3(cand1);
   assign any_req = |bus.req;
   assign pick    = bus.req[cand0] ? cand0 :
                    bus.req[cand1] ? cand1 : cand2;

   assign owner_req  = bus.req[owner_q];
   assign owner_last = bus.last[owner_q];
   assign valid      = (state_q == BUSY) && owner_req;
   assign xfer       = valid && bus.out_ready;
   assign cnt_inc    = cnt_q + CNT_W'(1);

   // Withdrawal ends the grant without a beat; otherwise only a transferred beat can end it.
   assign grant_end  = !owner_req || (xfer && (owner_last || (cnt_inc == HOLD_LIM)));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      s_d     = s_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            gnt_d = 3'b000;
            if (any_req) begin
               owner_d = pick;
               gnt_d   = 3'b001 << pick;
               s_d     = pick;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (grant_end) begin
               gnt_d   = 3'b000;
               ptr_d   = next_mod3(owner_q);
               cnt_d   = '0;
               state_d = IDLE;
            end else if (xfer) begin
               cnt_d   = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         ptr_q   <= 2'd0;
         s_q     <= 2'd0;
         gnt_q   <= 3'b000;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         s_q     <= s_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.s         = s_q;
   assign bus.busy      = (state_q == BUSY);
   assign bus.out_valid = valid;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: a scoreboard of expected beats is
// filled as stimulus is driven and drained by the beat monitor.
module tb_mux3_rr_arbiter;

   typedef struct {
      logic [1:0] src;
      logic [7:0] data;
   } beat_t;

   logic clk;
   logic rst_n;

   mux3_rr_arbiter_if bus  ();
   mux3_rr_arbiter_if bus1 ();

   logic [7:0] d0, d1, d2;
   logic [7:0] mux_out;

   beat_t exp_q[$];
   int    vectors;
   int    miscompares;

   mux3_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Second instance with MAX_HOLD=1 sees the same stimulus.
   mux3_rr_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   assign bus1.req       = bus.req;
   assign bus1.last      = bus.last;
   assign bus1.out_ready = bus.out_ready;

   // Model of the mux33 datapath driven by the arbiter select.
   always_comb begin
      case (bus.s)
         2'd0:    mux_out = d0;
         2'd1:    mux_out = d1;
         2'd2:    mux_out = d2;
         default: mux_out = 8'hxx;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] data_of(input logic [1:0] src);
      return (src == 2'd0) ? 8'h11 : (src == 2'd1) ? 8'h22 : 8'h33;
   endfunction

   task automatic push_beat(input logic [1:0] src);
      beat_t b;
      b.src  = src;
      b.data = data_of(src);
      exp_q.push_back(b);
   endtask

   // Sample the current cycle at the falling edge and retire any transferred beat.
   task automatic sample();
      beat_t e;
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL beat_unexpected: got s=%0d data=%h, required no beat", bus.s, mux_out);
         end else begin
            e = exp_q.pop_front();
            if (bus.s !== e.src || mux_out !== e.data) begin
               miscompares++;
               $display("FAIL beat_order: got s=%0d data=%h, required s=%0d data=%h",
                        bus.s, mux_out, e.src, e.data);
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string name);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req       = 3'b000;
      bus.last      = 3'b000;
      bus.out_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.req       = 3'b111;
      bus.last      = 3'b000;
      bus.out_ready = 1'b0;
      advance();
      sample();
      vectors++;
      if (bus.gnt !== 3'b000 || bus.s !== 2'b00 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got gnt=%b s=%b ov=%b busy=%b, required 000 00 0 0",
                  bus.gnt, bus.s, bus.out_valid, bus.busy);
      end
      advance();
      rst_n = 1'b1;
      advance();
      sample();
      vectors++;
      if (bus.gnt !== 3'b001 || bus.s !== 2'b00 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_first_grant: got gnt=%b s=%b busy=%b, required 001 00 1",
                  bus.gnt, bus.s, bus.busy);
      end
      advance();
   endtask

   task automatic test_round_robin();
      logic       exp_busy;
      logic [2:0] exp_gnt;
      do_reset();
      bus.req       = 3'b111;
      bus.last      = 3'b111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_beat(2'(i % 3));
      for (int k = 0; k < 12; k++) begin
         sample();
         exp_busy = (k % 2) == 1;
         exp_gnt  = exp_busy ? (3'b001 << ((k / 2) % 3)) : 3'b000;
         vectors++;
         if (bus.busy !== exp_busy || bus.gnt !== exp_gnt) begin
            miscompares++;
            $display("FAIL rr_cycle%0d: got busy=%b gnt=%b, required busy=%b gnt=%b",
                     k, bus.busy, bus.gnt, exp_busy, exp_gnt);
         end
         vectors++;
         if (bus1.gnt !== exp_gnt) begin
            miscompares++;
            $display("FAIL rr_hold1_cycle%0d: got gnt=%b, required %b", k, bus1.gnt, exp_gnt);
         end
         advance();
      end
      bus.req = 3'b000;
      sample();
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_end_idle: got busy=%b, required 0", bus.busy);
      end
      check_drained("rr");
   endtask

   task automatic test_hold_limit();
      logic       exp_busy;
      logic [2:0] exp_gnt1;
      do_reset();
      bus.req       = 3'b101;
      bus.last      = 3'b000;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_beat(2'd0);
      for (int i = 0; i < 4; i++) push_beat(2'd2);
      for (int k = 0; k < 10; k++) begin
         sample();
         exp_busy = !(k == 0 || k == 5);
         vectors++;
         if (bus.busy !== exp_busy || (exp_busy && bus.s !== ((k < 5) ? 2'd0 : 2'd2))) begin
            miscompares++;
            $display("FAIL hold_cycle%0d: got busy=%b s=%0d, required busy=%b s=%0d",
                     k, bus.busy, bus.s, exp_busy, (k < 5) ? 0 : 2);
         end
         exp_gnt1 = ((k % 2) == 0) ? 3'b000 : (((k / 2) % 2) == 0) ? 3'b001 : 3'b100;
         vectors++;
         if (bus1.gnt !== exp_gnt1) begin
            miscompares++;
            $display("FAIL hold1_cycle%0d: got gnt=%b, required %b", k, bus1.gnt, exp_gnt1);
         end
         advance();
      end
      bus.req = 3'b000;
      sample();
      vectors++;
      if (bus.busy !== 1'b0 || bus.gnt !== 3'b000) begin
         miscompares++;
         $display("FAIL hold_end: got busy=%b gnt=%b, required 0 000", bus.busy, bus.gnt);
      end
      check_drained("hold");
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.req       = 3'b010;
      bus.last      = 3'b000;
      bus.out_ready = 1'b0;
      sample();
      advance();
      for (int k = 1; k <= 5; k++) begin
         sample();
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.s !== 2'b01 || bus.gnt !== 3'b010 || dut.cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL bp_stall%0d: got ov=%b s=%b gnt=%b cnt=%0d, required 1 01 010 0",
                     k, bus.out_valid, bus.s, bus.gnt, dut.cnt_q);
         end
         advance();
      end
      bus.out_ready = 1'b1;
      bus.last      = 3'b010;
      push_beat(2'd1);
      sample();
      advance();
      bus.req = 3'b000;
      sample();
      vectors++;
      if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release: got gnt=%b busy=%b, required 000 0", bus.gnt, bus.busy);
      end
      check_drained("bp");
   endtask

   task automatic test_withdrawal();
      do_reset();
      bus.req       = 3'b100;
      bus.out_ready = 1'b0;
      sample();
      advance();
      sample();
      vectors++;
      if (bus.gnt !== 3'b100 || bus.s !== 2'b10) begin
         miscompares++;
         $display("FAIL wd_owner: got gnt=%b s=%b, required 100 10", bus.gnt, bus.s);
      end
      advance();
      bus.req = 3'b001;
      sample();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL wd_drop: got ov=%b busy=%b, required 0 1", bus.out_valid, bus.busy);
      end
      advance();
      sample();
      vectors++;
      if (bus.busy !== 1'b0 || bus.gnt !== 3'b000 || dut.ptr_q !== 2'd0) begin
         miscompares++;
         $display("FAIL wd_idle: got busy=%b gnt=%b ptr=%0d, required 0 000 0",
                  bus.busy, bus.gnt, dut.ptr_q);
      end
      advance();
      sample();
      vectors++;
      if (bus.gnt !== 3'b001) begin
         miscompares++;
         $display("FAIL wd_regrant: got gnt=%b, required 001", bus.gnt);
      end
      advance();
      check_drained("wd");
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.req       = 3'b001;
      bus.last      = 3'b001;
      bus.out_ready = 1'b1;
      push_beat(2'd0);
      sample();
      advance();
      sample();
      advance();
      sample();
      vectors++;
      if (bus.busy !== 1'b0 || dut.ptr_q !== 2'd1) begin
         miscompares++;
         $display("FAIL ar_ptr_adv: got busy=%b ptr=%0d, required 0 1", bus.busy, dut.ptr_q);
      end
      advance();
      bus.out_ready = 1'b0;
      sample();
      vectors++;
      if (bus.busy !== 1'b1 || bus.gnt !== 3'b001 || dut.ptr_q !== 2'd1) begin
         miscompares++;
         $display("FAIL ar_busy: got busy=%b gnt=%b ptr=%0d, required 1 001 1",
                  bus.busy, bus.gnt, dut.ptr_q);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.gnt !== 3'b000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || dut.ptr_q !== 2'd0) begin
         miscompares++;
         $display("FAIL ar_immediate: got gnt=%b ov=%b busy=%b ptr=%0d, required 000 0 0 0",
                  bus.gnt, bus.out_valid, bus.busy, dut.ptr_q);
      end
      check_drained("ar");
      advance();
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      d0          = 8'h11;
      d1          = 8'h22;
      d2          = 8'h33;
      rst_n       = 1'b0;
      bus.req       = 3'b000;
      bus.last      = 3'b000;
      bus.out_ready = 1'b0;
      test_reset();
      test_round_robin();
      test_hold_limit();
      test_backpressure();
      test_withdrawal();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux3_rr_arbiter.md
# mux3_rr_arbiter

Round-robin arbiter and sequencer for the 3-input, 8-bit `mux33` datapath. Three requesters share the mux. The block grants one requester at a time, drives the mux select `s`, and presents a valid/ready beat stream downstream. Grants end on a requester's last beat, on withdrawal, or after a bounded number of beats, so no requester can starve the others.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum accepted beats per grant before forced rotation; legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  3  per-requester request; bit i set means requester i has a beat on mux input `d<i>`.
- `last`  input  3  per-requester final-beat flag; sampled only for the current owner.
- `gnt`  output  3  one-hot grant, registered; zero when no owner.
- `s`  output  2  mux33 select (00 = d0, 01 = d1, 10 = d2), registered; value 11 is never driven.
- `out_valid`  output  1  downstream beat valid; equals `req[owner]` while busy, else 0.
- `out_ready`  input  1  downstream accept.
- `busy`  output  1  high while a grant is held.

## Operation
- Internal state:
  - FSM with states IDLE and BUSY.
  - `owner` register, 2 bits.
  - Priority pointer `ptr`, 2 bits, values 0..2.
  - Beat counter `cnt`, width sufficient for `MAX_HOLD`.
- **IDLE:**
  - If `req` is nonzero, select the first set bit searching `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - Then: `owner` = selected, `gnt` = onehot(selected), `s` = selected, `cnt` = 0, go to BUSY.
  - If `req` is zero, stay in IDLE. `s` holds its last value and `gnt` = 0.
- **BUSY:**
  - `out_valid` = `req[owner]`. A beat transfers when `out_valid && out_ready`; `cnt` increments on each transfer.
  - The grant ends at the clock edge after any of the following:
    - a transferred beat with `last[owner]` = 1;
    - a transferred beat that makes `cnt` reach `MAX_HOLD`;
    - `req[owner]` = 0 (withdrawal; no beat transfers).
  - On grant end: `gnt` = 0, `ptr` = (`owner`+1) mod 3, `cnt` = 0, go to IDLE.
- `out_ready` without `out_valid` is ignored. `last` bits of non-owners are ignored.
- Requests arriving for non-owners while BUSY are held by the requester (level-sensitive) and arbitrated in the next IDLE cycle.
- `s` never changes while BUSY, so owner data reaches the mux output stably.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - FSM = IDLE, `gnt` = 000, `s` = 00, `out_valid` = 0, `busy` = 0, `ptr` = 0, `owner` = 0, `cnt` = 0.
- Reset asserted mid-grant drops the grant immediately; the in-flight beat is lost and is not counted.
- `req` to `gnt` latency: 1 cycle (`req` sampled in IDLE at edge N, `gnt`/`s`/`busy` valid after edge N).
- `out_valid` is combinational from `req[owner]` and FSM state. It is valid in the first BUSY cycle.
- Throughput: one beat per cycle while BUSY and `out_ready` = 1.
- There is one mandatory IDLE cycle between grants. A `MAX_HOLD`=4 stream therefore sustains 4 beats per 5 cycles.
- Simultaneous `last` and `cnt` reaching `MAX_HOLD`: the grant ends once; `ptr` advances by one.
- Simultaneous requests from all three requesters after reset: requester 0 wins, then 1, then 2, then 0.
- With `MAX_HOLD`=1, every grant is exactly one transferred beat.

## Test plan
- Reset check: hold `rst_n`=0 with `req`=111 → `gnt`=000, `s`=00, `out_valid`=0. Release → after 1 edge `gnt`=001, `s`=00, `busy`=1.
- Round-robin: hold `req`=111, `out_ready`=1, `last`=111, drive `d0`=8'h11, `d1`=8'h22, `d2`=8'h33.
  - Mux output sequence must be 11, 22, 33, 11, …, each beat separated by one IDLE cycle.
  - `s` sequence must be 00, 01, 10.
- Hold limit: `MAX_HOLD`=4, `req`=101, `last`=000, `out_ready`=1 → exactly 4 beats from requester 0, then IDLE, then 4 beats from requester 2 (`s`=10).
- Backpressure: owner 1, `out_ready`=0 for 5 cycles → `out_valid`=1, `cnt` unchanged, `s`=01 stable. Raise `out_ready` with `last[1]`=1 → one beat, then `gnt`=000.
- Withdrawal: owner 2 drops `req[2]` mid-grant with `req[0]`=1 → next edge IDLE, `ptr`=0, following edge `gnt`=001.
- Async reset mid-grant: assert `rst_n`=0 between edges while BUSY → `gnt`=000, `out_valid`=0 immediately without a clock edge. `ptr` returns to 0.
